// File: rtl/multicycle_control_unit_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package multicycle_control_unit_pkg;

  localparam int unsigned OPCODE_W = 7;

  localparam logic [OPCODE_W-1:0] OP_ARITH     = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LOAD      = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE     = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH    = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL       = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR      = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OP_ECALL     = 7'b1110011;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IF,
    ST_ID,
    ST_EX,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_BRANCH = 2'd1;
  localparam logic [1:0] ALU_FUNCT  = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MDR = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;

  // Datapath strobe and mux bundle produced by the FSM each cycle.
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       mdr_write;
    logic       alu_out_write;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_known_op(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_STORE,
      OP_BRANCH, OP_JAL, OP_JALR, OP_ECALL: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control unit <-> datapath/memory signal bundle.
interface multicycle_control_unit_if
  import multicycle_control_unit_pkg::*;
#(
  parameter int unsigned CNT_W = 32
);

  logic [OPCODE_W-1:0] opcode;
  logic                alu_bcond;
  logic                halt_req;
  logic                mem_ready;

  logic                mem_read;
  logic                mem_write;
  logic                i_or_d;
  logic                ir_write;
  logic                mdr_write;
  logic                alu_out_write;
  logic                alu_src_b;
  logic [1:0]          alu_op;
  logic                reg_write;
  logic [1:0]          wb_sel;
  logic                pc_write;
  logic [1:0]          pc_source;
  logic                illegal_op;
  logic                is_halted;
  logic [CNT_W-1:0]    instret;

  modport master (
    input  opcode, alu_bcond, halt_req, mem_ready,
    output mem_read, mem_write, i_or_d, ir_write, mdr_write, alu_out_write,
           alu_src_b, alu_op, reg_write, wb_sel, pc_write, pc_source,
           illegal_op, is_halted, instret
  );

  modport slave (
    output opcode, alu_bcond, halt_req, mem_ready,
    input  mem_read, mem_write, i_or_d, ir_write, mdr_write, alu_out_write,
           alu_src_b, alu_op, reg_write, wb_sel, pc_write, pc_source,
           illegal_op, is_halted, instret
  );

endinterface

// File: rtl/multicycle_control_unit_mem_wait_timer.sv
// Fixed-latency memory access timer: done once LATENCY cycles have elapsed since clear.
module mem_wait_timer #(
  parameter int unsigned LATENCY = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int unsigned CW = $clog2(LATENCY + 1);

  logic [CW-1:0] cnt_q;

  assign done = (cnt_q == CW'(LATENCY - 1));

  // Holds at the done value so a stalled consumer never sees it wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !done) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences IF/ID/EX/MEM/WB and drives datapath strobes.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter int unsigned MEM_LATENCY   = 1,
  parameter int unsigned CNT_W         = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  multicycle_control_unit_if.master   bus
);

  state_e           state_q, state_d;
  ctrl_t            ctrl;
  logic             done;
  logic             timer_done;
  logic             timer_clear;
  logic             timer_en;
  logic             halted_q;
  logic [CNT_W-1:0] instret_q;

  // Timer state stays constant in handshake mode and is optimised away.
  assign timer_en    = !MEM_HANDSHAKE && (state_q == ST_IF || state_q == ST_MEM);
  assign timer_clear = !MEM_HANDSHAKE && (state_d != state_q) &&
                       (state_d == ST_IF || state_d == ST_MEM);

  mem_wait_timer #(
    .LATENCY (MEM_LATENCY)
  ) u_mem_wait_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .enable  (timer_en),
    .done    (timer_done)
  );

  assign done = MEM_HANDSHAKE ? bus.mem_ready : timer_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and strobes; only the listed strobes are raised in each state.
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    case (state_q)
      ST_INIT: state_d = ST_IF;

      ST_IF: begin
        ctrl.mem_read = 1'b1;
        if (done) begin
          ctrl.ir_write = 1'b1;
          state_d       = ST_ID;
        end
      end

      ST_ID: begin
        if (bus.opcode == OP_ECALL) begin
          ctrl.pc_write = 1'b1;
          state_d       = bus.halt_req ? ST_HALT : ST_IF;
        end else if (!is_known_op(bus.opcode)) begin
          ctrl.illegal_op = 1'b1;
          ctrl.pc_write   = 1'b1;
          state_d         = ST_IF;
        end else begin
          state_d = ST_EX;
        end
      end

      ST_EX: begin
        ctrl.alu_out_write = 1'b1;
        case (bus.opcode)
          OP_ARITH: begin
            ctrl.alu_op = ALU_FUNCT;
            state_d     = ST_WB;
          end
          OP_ARITH_IMM: begin
            ctrl.alu_src_b = 1'b1;
            ctrl.alu_op    = ALU_FUNCT;
            state_d        = ST_WB;
          end
          OP_LOAD, OP_STORE: begin
            ctrl.alu_src_b = 1'b1;
            state_d        = ST_MEM;
          end
          OP_JALR: begin
            ctrl.alu_src_b = 1'b1;
            state_d        = ST_WB;
          end
          OP_BRANCH: begin
            ctrl.alu_op    = ALU_BRANCH;
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = bus.alu_bcond ? PC_BRANCH : PC_PLUS4;
            state_d        = ST_IF;
          end
          OP_JAL: state_d = ST_WB;
          default: begin
            ctrl.pc_write = 1'b1;
            state_d       = ST_IF;
          end
        endcase
      end

      ST_MEM: begin
        ctrl.i_or_d = 1'b1;
        if (bus.opcode == OP_STORE) begin
          ctrl.mem_write = 1'b1;
          if (done) begin
            ctrl.pc_write = 1'b1;
            state_d       = ST_IF;
          end
        end else begin
          ctrl.mem_read = 1'b1;
          if (done) begin
            ctrl.mdr_write = 1'b1;
            state_d        = ST_WB;
          end
        end
      end

      ST_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.pc_write  = 1'b1;
        state_d        = ST_IF;
        case (bus.opcode)
          OP_LOAD: ctrl.wb_sel = WB_MDR;
          OP_JAL: begin
            ctrl.wb_sel    = WB_PC4;
            ctrl.pc_source = PC_BRANCH;
          end
          OP_JALR: begin
            ctrl.wb_sel    = WB_PC4;
            ctrl.pc_source = PC_JALR;
          end
          default: ctrl.wb_sel = WB_ALU;
        endcase
      end

      ST_HALT: state_d = ST_HALT;

      default: state_d = ST_INIT;
    endcase
  end

  // Retired-instruction counter and sticky halt flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instret_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      if (ctrl.pc_write) begin
        instret_q <= instret_q + CNT_W'(1);
      end
      if (state_d == ST_HALT) begin
        halted_q <= 1'b1;
      end
    end
  end

  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.i_or_d        = ctrl.i_or_d;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.mdr_write     = ctrl.mdr_write;
  assign bus.alu_out_write = ctrl.alu_out_write;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.wb_sel        = ctrl.wb_sel;
  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.illegal_op    = ctrl.illegal_op;
  assign bus.is_halted     = halted_q;
  assign bus.instret       = instret_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: fixed latency 1 and 3, and handshake mode.
module tb_multicycle_control_unit;
  import multicycle_control_unit_pkg::*;

  // Observed vector layout, MSB first:
  // mem_read mem_write i_or_d ir_write mdr_write alu_out_write alu_src_b alu_op[2]
  // reg_write wb_sel[2] pc_write pc_source[2] illegal_op
  localparam logic [15:0] V_IDLE = 16'h0000;
  localparam logic [15:0] V_IFW  = 16'h8000;
  localparam logic [15:0] V_IFD  = 16'h9000;
  localparam logic [15:0] V_IDPC = 16'h0008;
  localparam logic [15:0] V_ILL  = 16'h0009;
  localparam logic [15:0] V_EXR  = 16'h0500;
  localparam logic [15:0] V_EXI  = 16'h0700;
  localparam logic [15:0] V_EXA  = 16'h0600;
  localparam logic [15:0] V_BRT  = 16'h048A;
  localparam logic [15:0] V_BRN  = 16'h0488;
  localparam logic [15:0] V_EXJ  = 16'h0400;
  localparam logic [15:0] V_LDW  = 16'hA000;
  localparam logic [15:0] V_LDD  = 16'hA800;
  localparam logic [15:0] V_STW  = 16'h6000;
  localparam logic [15:0] V_STD  = 16'h6008;
  localparam logic [15:0] V_WBR  = 16'h0048;
  localparam logic [15:0] V_WBL  = 16'h0058;
  localparam logic [15:0] V_WBJ  = 16'h006A;
  localparam logic [15:0] V_WBJR = 16'h006C;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multicycle_control_unit_if #(.CNT_W(4))  if_a ();
  multicycle_control_unit_if #(.CNT_W(32)) if_b ();
  multicycle_control_unit_if #(.CNT_W(8))  if_c ();

  multicycle_control_unit #(.MEM_HANDSHAKE(1'b0), .MEM_LATENCY(1), .CNT_W(4)) u_lat1 (
    .clk(clk), .reset_n(rst_a), .bus(if_a));
  multicycle_control_unit #(.MEM_HANDSHAKE(1'b0), .MEM_LATENCY(3), .CNT_W(32)) u_lat3 (
    .clk(clk), .reset_n(rst_b), .bus(if_b));
  multicycle_control_unit #(.MEM_HANDSHAKE(1'b1), .MEM_LATENCY(1), .CNT_W(8)) u_hs (
    .clk(clk), .reset_n(rst_c), .bus(if_c));

  logic [15:0] va, vb, vc;
  assign va = {if_a.mem_read, if_a.mem_write, if_a.i_or_d, if_a.ir_write, if_a.mdr_write,
               if_a.alu_out_write, if_a.alu_src_b, if_a.alu_op, if_a.reg_write, if_a.wb_sel,
               if_a.pc_write, if_a.pc_source, if_a.illegal_op};
  assign vb = {if_b.mem_read, if_b.mem_write, if_b.i_or_d, if_b.ir_write, if_b.mdr_write,
               if_b.alu_out_write, if_b.alu_src_b, if_b.alu_op, if_b.reg_write, if_b.wb_sel,
               if_b.pc_write, if_b.pc_source, if_b.illegal_op};
  assign vc = {if_c.mem_read, if_c.mem_write, if_c.i_or_d, if_c.ir_write, if_c.mdr_write,
               if_c.alu_out_write, if_c.alu_src_b, if_c.alu_op, if_c.reg_write, if_c.wb_sel,
               if_c.pc_write, if_c.pc_source, if_c.illegal_op};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Each cycle: step past the rising edge, drive inputs, then sample settled outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ca(input string tag, input logic [15:0] e);
    #1;
    chk(tag, 32'(va), 32'(e));
  endtask

  task automatic cb(input string tag, input logic [15:0] e);
    #1;
    chk(tag, 32'(vb), 32'(e));
  endtask

  task automatic cc(input string tag, input logic [15:0] e);
    #1;
    chk(tag, 32'(vc), 32'(e));
  endtask

  // One instruction on the latency-1 unit; opcode changes only once IF has begun.
  task automatic run_a(input string tag, input logic [6:0] op, input logic bc, input int n,
                       input logic [15:0] e [5], input int cnt);
    for (int i = 0; i < n; i++) begin
      tick();
      if (i == 0) begin
        if_a.opcode    = op;
        if_a.alu_bcond = bc;
      end
      ca($sformatf("%s_c%0d", tag, i), e[i]);
      if (i == 0) chk($sformatf("%s_instret", tag), 32'(if_a.instret), 32'(cnt));
    end
  endtask

  logic [15:0] load_b [9];

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    if_a.opcode = '0; if_a.alu_bcond = 1'b0; if_a.halt_req = 1'b0; if_a.mem_ready = 1'b0;
    if_b.opcode = '0; if_b.alu_bcond = 1'b0; if_b.halt_req = 1'b0; if_b.mem_ready = 1'b0;
    if_c.opcode = '0; if_c.alu_bcond = 1'b0; if_c.halt_req = 1'b0; if_c.mem_ready = 1'b0;

    // Reset state
    tick();
    ca("a_rst_vec", V_IDLE);
    chk("a_rst_instret", 32'(if_a.instret), 32'd0);
    chk("a_rst_halted", 32'(if_a.is_halted), 32'd0);
    rst_a = 1'b1;

    // Latency-1 instruction mix
    run_a("add",  OP_ARITH,     1'b0, 4, '{V_IFD, V_IDLE, V_EXR, V_WBR, V_IDLE}, 0);
    run_a("br_t", OP_BRANCH,    1'b1, 3, '{V_IFD, V_IDLE, V_BRT, V_IDLE, V_IDLE}, 1);
    run_a("br_n", OP_BRANCH,    1'b0, 3, '{V_IFD, V_IDLE, V_BRN, V_IDLE, V_IDLE}, 2);
    run_a("st",   OP_STORE,     1'b0, 4, '{V_IFD, V_IDLE, V_EXA, V_STD, V_IDLE}, 3);
    run_a("jal",  OP_JAL,       1'b0, 4, '{V_IFD, V_IDLE, V_EXJ, V_WBJ, V_IDLE}, 4);
    run_a("jalr", OP_JALR,      1'b0, 4, '{V_IFD, V_IDLE, V_EXA, V_WBJR, V_IDLE}, 5);
    run_a("addi", OP_ARITH_IMM, 1'b0, 4, '{V_IFD, V_IDLE, V_EXI, V_WBR, V_IDLE}, 6);
    run_a("ill",  7'h7F,        1'b0, 2, '{V_IFD, V_ILL, V_IDLE, V_IDLE, V_IDLE}, 7);
    for (int k = 8; k < 16; k++) begin
      run_a("ecall", OP_ECALL, 1'b0, 2, '{V_IFD, V_IDPC, V_IDLE, V_IDLE, V_IDLE}, k);
    end
    run_a("wrap_ld", OP_LOAD,   1'b0, 5, '{V_IFD, V_IDLE, V_EXA, V_LDD, V_WBL}, 0);
    tick();
    chk("a_after_ld_instret", 32'(if_a.instret), 32'd1);
    chk("a_not_halted", 32'(if_a.is_halted), 32'd0);

    // Latency-3 load: 3 IF cycles, ID, EX, 3 MEM cycles, WB
    load_b = '{V_IFW, V_IFW, V_IFD, V_IDLE, V_EXA, V_LDW, V_LDW, V_LDD, V_WBL};
    rst_b = 1'b1;
    cb("b_init", V_IDLE);
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i == 0) if_b.opcode = OP_LOAD;
      cb($sformatf("b_load_c%0d", i), load_b[i]);
    end
    tick();
    cb("b_next_if", V_IFW);
    chk("b_instret", 32'(if_b.instret), 32'd1);

    // Handshake: IF stalls until mem_ready
    rst_c = 1'b1;
    cc("c_init", V_IDLE);
    for (int i = 0; i < 5; i++) begin
      tick();
      cc($sformatf("c_if_stall%0d", i), V_IFW);
    end
    tick();
    if_c.mem_ready = 1'b1;
    if_c.opcode    = OP_ECALL;
    cc("c_if_ready", V_IFD);
    tick();
    cc("c_ecall_id", V_IDPC);
    tick();
    cc("c_if_entry_ready", V_IFD);
    chk("c_instret1", 32'(if_c.instret), 32'd1);
    if_c.opcode = OP_STORE;
    tick();
    if_c.mem_ready = 1'b0;
    cc("c_st_id", V_IDLE);
    tick();
    cc("c_st_ex", V_EXA);
    tick();
    cc("c_st_mem0", V_STW);
    tick();
    cc("c_st_mem1", V_STW);

    // Reset in the middle of the store access
    rst_c = 1'b0;
    cc("c_rst_drop", V_IDLE);
    chk("c_rst_instret", 32'(if_c.instret), 32'd0);
    tick();
    cc("c_rst_hold", V_IDLE);
    rst_c = 1'b1;
    cc("c_rel_init", V_IDLE);
    tick();
    cc("c_rel_if", V_IFW);

    // Halt and its immunity to mem_ready
    if_c.mem_ready = 1'b1;
    if_c.opcode    = OP_ECALL;
    if_c.halt_req  = 1'b1;
    cc("c_h_if", V_IFD);
    tick();
    cc("c_h_id", V_IDPC);
    chk("c_h_id_halted", 32'(if_c.is_halted), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if_c.mem_ready = i[0];
      cc($sformatf("c_halt%0d", i), V_IDLE);
      chk($sformatf("c_halted%0d", i), 32'(if_c.is_halted), 32'd1);
    end
    chk("c_halt_instret", 32'(if_c.instret), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
